// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - RV32I execute stage: ALU decode plus registered EX/MEM result slot
// Optional feature: define ALU_EXEC_OVF_EN to add the registered signed-overflow output.
module alu_exec_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [4:0]      rd_out,
    output logic            illegal_op
`ifdef ALU_EXEC_OVF_EN
    ,
    output logic            overflow
`endif
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic [4:0]      r_rd;
    logic            r_illegal;
    logic            r_valid;

    logic [XLEN-1:0] w_result;
    logic            w_illegal;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic [SHW-1:0]  w_shamt;
    logic            w_accept;

    assign w_sum    = src_a + src_b;
    assign w_diff   = src_a - src_b;
    assign w_shamt  = src_b[SHW-1:0];

    // The slot can take new data when empty or when its current result leaves this cycle.
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    // Operation decode; unknown or undriven codes fall through to the illegal default.
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (alu_ctrl)
            4'b0000: w_result = w_sum;
            4'b0001: w_result = w_diff;
            4'b0010: w_result = src_a & src_b;
            4'b0011: w_result = src_a | src_b;
            4'b0110: w_result = src_a ^ src_b;
            4'b0100: w_result = src_a << w_shamt;
            4'b0111: w_result = src_a >> w_shamt;
            4'b1111: w_result = $unsigned($signed(src_a) >>> w_shamt);
            4'b0101: w_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b1000: w_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            default: begin
                w_result  = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Result slot: flush kills the slot, accept reloads it, a drain without refill empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_rd      <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid   <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_result  <= w_result;
            r_zero    <= (w_result == '0);
            r_rd      <= rd_in;
            r_illegal <= w_illegal;
        end else if (out_ready) begin
            r_valid   <= 1'b0;
        end
    end

`ifdef ALU_EXEC_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Signed overflow: add with like-signed operands, or sub with unlike-signed operands,
    // whose result sign disagrees with operand A.
    always_comb begin
        w_ovf = 1'b0;
        case (alu_ctrl)
            4'b0000: w_ovf = (src_a[XLEN-1] == src_b[XLEN-1]) && (w_sum[XLEN-1] != src_a[XLEN-1]);
            4'b0001: w_ovf = (src_a[XLEN-1] != src_b[XLEN-1]) && (w_diff[XLEN-1] != src_a[XLEN-1]);
            default: w_ovf = 1'b0;
        endcase
    end

    // Overflow flag travels with the result under the same load/hold rules.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (!flush && w_accept) begin
            r_ovf <= w_ovf;
        end
    end

    assign overflow = r_ovf;
`endif

    assign out_valid  = r_valid;
    assign result     = r_result;
    assign zero       = r_zero;
    assign rd_out     = r_rd;
    assign illegal_op = r_illegal;

endmodule
